// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// Module   : trap_controller
// Brief    : Machine-mode trap entry / mret sequencer. Synchronizes and
//            prioritizes MEI/MSI/MTI, arbitrates them against synchronous
//            exceptions and mret, and emits one-cycle trap/return strobes
//            with cause and redirect PC for the CSR file and fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module trap_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        soft_irq,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        mie_msie,
    input  logic        stall,
    input  logic        exception_valid,
    input  logic [3:0]  exception_cause,
    input  logic        mret,
    input  logic [29:0] mtvec_base,
    input  logic [29:0] mepc,
    output logic        trap,
    output logic        return_from_trap,
    output logic        interrupt,
    output logic [30:0] exception_code,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        mip_meip,
    output logic        mip_mtip,
    output logic        mip_msip,
    output logic        busy
);

    // Interrupt cause codes (machine external / software / timer).
    localparam logic [30:0] c_CODE_MEI = 31'd11;
    localparam logic [30:0] c_CODE_MSI = 31'd3;
    localparam logic [30:0] c_CODE_MTI = 31'd7;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_TRAP   = 3'd2,
        ST_RETURN = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Pending-level registers.
    logic [SYNC_STAGES-1:0] r_ext_sync;
    logic                   r_mtip;
    logic                   r_msip;

    // Registered outputs.
    logic        r_trap;
    logic        r_return;
    logic        r_redirect_valid;
    logic [31:0] r_redirect_pc;
    logic        r_interrupt;
    logic [30:0] r_code;

    // Combinational decision signals.
    logic        w_pend_mei;
    logic        w_pend_msi;
    logic        w_pend_mti;
    logic        w_take_irq;
    logic [30:0] w_irq_code;
    logic        w_evaluate;
    logic        w_go_trap;
    logic        w_go_return;
    logic        w_next_interrupt;
    logic [30:0] w_next_code;

    // ext_irq is asynchronous: shift it through the synchronizer chain.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ext_sync <= '0;
        end else begin
            r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], ext_irq};
        end
    end

    // Timer and software levels are already synchronous; register them once.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_mtip <= 1'b0;
            r_msip <= 1'b0;
        end else begin
            r_mtip <= timer_irq;
            r_msip <= soft_irq;
        end
    end

    assign mip_meip = r_ext_sync[SYNC_STAGES-1];
    assign mip_mtip = r_mtip;
    assign mip_msip = r_msip;

    // Enabled pending sources and fixed-priority cause selection.
    assign w_pend_mei = mip_meip & mie_meie;
    assign w_pend_msi = r_msip   & mie_msie;
    assign w_pend_mti = r_mtip   & mie_mtie;
    assign w_take_irq = mstatus_mie & (w_pend_mei | w_pend_msi | w_pend_mti);
    assign w_irq_code = w_pend_mei ? c_CODE_MEI :
                        w_pend_msi ? c_CODE_MSI : c_CODE_MTI;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE and DRAIN share one arbitration at an
    // instruction boundary (exception > mret > interrupt).
    always_comb begin
        w_state_next     = r_state;
        w_evaluate       = 1'b0;
        w_go_trap        = 1'b0;
        w_go_return      = 1'b0;
        w_next_interrupt = 1'b0;
        w_next_code      = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (!stall) begin
                    w_evaluate = 1'b1;
                end else if (w_take_irq) begin
                    // Interrupt wants service but the core is mid-instruction.
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    // Falls back to IDLE if the arbitration below finds nothing.
                    w_evaluate   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_TRAP: begin
                w_state_next = ST_SETTLE;
            end
            ST_RETURN: begin
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                // One dead cycle lets the CSR file's mstatus update land.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_evaluate) begin
            if (exception_valid) begin
                w_state_next     = ST_TRAP;
                w_go_trap        = 1'b1;
                w_next_interrupt = 1'b0;
                w_next_code      = {27'b0, exception_cause};
            end else if (mret) begin
                w_state_next = ST_RETURN;
                w_go_return  = 1'b1;
            end else if (w_take_irq) begin
                w_state_next     = ST_TRAP;
                w_go_trap        = 1'b1;
                w_next_interrupt = 1'b1;
                w_next_code      = w_irq_code;
            end
        end
    end

    // Strobes, redirect and cause are registered on entry to TRAP/RETURN so
    // they are valid for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_trap           <= 1'b0;
            r_return         <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_interrupt      <= 1'b0;
            r_code           <= '0;
        end else begin
            r_trap           <= w_go_trap;
            r_return         <= w_go_return;
            r_redirect_valid <= w_go_trap | w_go_return;
            if (w_go_trap) begin
                r_redirect_pc <= {mtvec_base, 2'b00};
                r_interrupt   <= w_next_interrupt;
                r_code        <= w_next_code;
            end else if (w_go_return) begin
                r_redirect_pc <= {mepc, 2'b00};
            end
        end
    end

    assign trap             = r_trap;
    assign return_from_trap = r_return;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign interrupt        = r_interrupt;
    assign exception_code   = r_code;
    assign busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_controller
// Brief    : Directed scoreboard bench for trap_controller. Stimulus pushes
//            the expected trap/return events (with their cycle); a monitor
//            pops and compares whenever a strobe appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_controller;

    logic        clock;
    logic        reset_n;
    logic        ext_irq;
    logic        timer_irq;
    logic        soft_irq;
    logic        mstatus_mie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        mie_msie;
    logic        stall;
    logic        exception_valid;
    logic [3:0]  exception_cause;
    logic        mret;
    logic [29:0] mtvec_base;
    logic [29:0] mepc;
    logic        trap;
    logic        return_from_trap;
    logic        interrupt;
    logic [30:0] exception_code;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mip_meip;
    logic        mip_mtip;
    logic        mip_msip;
    logic        busy;

    trap_controller #(.SYNC_STAGES(2)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .ext_irq          (ext_irq),
        .timer_irq        (timer_irq),
        .soft_irq         (soft_irq),
        .mstatus_mie      (mstatus_mie),
        .mie_meie         (mie_meie),
        .mie_mtie         (mie_mtie),
        .mie_msie         (mie_msie),
        .stall            (stall),
        .exception_valid  (exception_valid),
        .exception_cause  (exception_cause),
        .mret             (mret),
        .mtvec_base       (mtvec_base),
        .mepc             (mepc),
        .trap             (trap),
        .return_from_trap (return_from_trap),
        .interrupt        (interrupt),
        .exception_code   (exception_code),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mip_meip         (mip_meip),
        .mip_mtip         (mip_mtip),
        .mip_msip         (mip_msip),
        .busy             (busy)
    );

    typedef struct {
        bit          is_trap;
        bit          intr;
        logic [30:0] code;
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter: during the cycle after edge k, cyc == k.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_trap(input bit intr, input logic [30:0] code, input logic [31:0] pc, input int at);
        exp_t e;
        e.is_trap = 1'b1; e.intr = intr; e.code = code; e.pc = pc; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic push_ret(input logic [31:0] pc, input int at);
        exp_t e;
        e.is_trap = 1'b0; e.intr = 1'b0; e.code = '0; e.pc = pc; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_trap"},           {31'b0, trap},             32'h0);
        chk({tag, "_return"},         {31'b0, return_from_trap}, 32'h0);
        chk({tag, "_redirect_valid"}, {31'b0, redirect_valid},   32'h0);
        chk({tag, "_redirect_pc"},    redirect_pc,               32'h0);
        chk({tag, "_exception_code"}, {1'b0, exception_code},    32'h0);
        chk({tag, "_interrupt"},      {31'b0, interrupt},        32'h0);
        chk({tag, "_busy"},           {31'b0, busy},             32'h0);
        chk({tag, "_mip"},            {29'b0, mip_meip, mip_mtip, mip_msip}, 32'h0);
    endtask

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge clock) begin
        exp_t e;
        if (trap || return_from_trap) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: trap=%0b return=%0b code=%0d with none expected (cycle %0d)",
                         trap, return_from_trap, exception_code, cyc);
            end else begin
                e = sb.pop_front();
                chk("event_cycle",      cyc,                       e.cyc);
                chk("event_trap",       {31'b0, trap},             {31'b0, e.is_trap});
                chk("event_return",     {31'b0, return_from_trap}, {31'b0, ~e.is_trap});
                chk("event_redirect_v", {31'b0, redirect_valid},   32'h1);
                chk("event_redirect_pc", redirect_pc,              e.pc);
                if (e.is_trap) begin
                    chk("event_interrupt", {31'b0, interrupt},    {31'b0, e.intr});
                    chk("event_code",      {1'b0, exception_code}, {1'b0, e.code});
                end
            end
        end else if (redirect_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL lone_redirect: redirect_valid=1 without strobe (cycle %0d)", cyc);
        end
    end

    initial begin
        reset_n = 1'b0; ext_irq = 1'b1; timer_irq = 1'b1; soft_irq = 1'b0;
        mstatus_mie = 1'b0; mie_meie = 1'b1; mie_mtie = 1'b1; mie_msie = 1'b1;
        stall = 1'b0; exception_valid = 1'b0; exception_cause = 4'd0; mret = 1'b0;
        mtvec_base = 30'h100; mepc = 30'h40;

        // Reset holds every output and sync flop at zero despite active levels.
        tick(3);
        chk_all_zero("reset");
        ext_irq = 1'b0; timer_irq = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(3);

        // Exception: cause 2, mtvec 0x100 -> trap next cycle at 0x400.
        exception_cause = 4'd2; exception_valid = 1'b1;
        push_trap(1'b0, 31'd2, 32'h0000_0400, cyc + 1);
        tick(1);
        exception_valid = 1'b0;
        chk("exc_busy_trap", {31'b0, busy}, 32'h1);
        tick(1);
        chk("exc_busy_settle", {31'b0, busy}, 32'h1);
        tick(1);
        chk("exc_busy_idle", {31'b0, busy}, 32'h0);
        tick(2);

        // mret: mepc 0x40 -> return next cycle at 0x100.
        mret = 1'b1;
        push_ret(32'h0000_0100, cyc + 1);
        tick(1);
        mret = 1'b0;
        tick(4);

        // Exception + mret together: exception first, mret 3 cycles later.
        exception_cause = 4'd5; exception_valid = 1'b1; mret = 1'b1;
        push_trap(1'b0, 31'd5, 32'h0000_0400, cyc + 1);
        push_ret(32'h0000_0100, cyc + 4);
        tick(1);
        exception_valid = 1'b0;
        tick(3);
        mret = 1'b0;
        tick(4);

        // Timer + software together: MSI (3) wins, two cycles later.
        mtvec_base = 30'h0ABC_DEF0;
        mstatus_mie = 1'b1; timer_irq = 1'b1; soft_irq = 1'b1;
        push_trap(1'b1, 31'd3, 32'h2AF3_7BC0, cyc + 2);
        tick(1);
        chk("mip_mtip_set", {31'b0, mip_mtip}, 32'h1);
        chk("mip_msip_set", {31'b0, mip_msip}, 32'h1);
        tick(1);
        mstatus_mie = 1'b0;   // CSR file clears MIE on trap entry
        tick(5);
        timer_irq = 1'b0; soft_irq = 1'b0;
        tick(2);

        // Timer alone -> code 7.
        mstatus_mie = 1'b1; timer_irq = 1'b1;
        push_trap(1'b1, 31'd7, 32'h2AF3_7BC0, cyc + 2);
        tick(2);
        mstatus_mie = 1'b0; timer_irq = 1'b0;
        tick(4);

        // Drain: ext_irq with stall for 5 cycles -> trap the cycle after stall falls.
        mstatus_mie = 1'b1; stall = 1'b1; ext_irq = 1'b1;
        tick(2);
        chk("drain_busy_before_sync", {31'b0, busy}, 32'h0);
        tick(1);
        chk("drain_busy_after_sync", {31'b0, busy}, 32'h1);
        tick(2);
        stall = 1'b0;
        push_trap(1'b1, 31'd11, 32'h2AF3_7BC0, cyc + 1);
        tick(1);
        mstatus_mie = 1'b0; ext_irq = 1'b0;
        tick(5);

        // Drain with ext_irq withdrawn mid-stall -> back to IDLE, no trap.
        mstatus_mie = 1'b1; stall = 1'b1; ext_irq = 1'b1;
        tick(4);
        chk("withdraw_busy", {31'b0, busy}, 32'h1);
        ext_irq = 1'b0;
        tick(4);
        stall = 1'b0;
        tick(1);
        chk("withdraw_idle", {31'b0, busy}, 32'h0);
        mstatus_mie = 1'b0;
        tick(3);

        // Exception (cause 11) beats pending timer; timer follows after SETTLE.
        timer_irq = 1'b1;
        tick(2);
        mstatus_mie = 1'b1; exception_cause = 4'd11; exception_valid = 1'b1;
        push_trap(1'b0, 31'd11, 32'h2AF3_7BC0, cyc + 1);
        push_trap(1'b1, 31'd7,  32'h2AF3_7BC0, cyc + 4);
        tick(1);
        exception_valid = 1'b0;
        tick(3);
        mstatus_mie = 1'b0;
        tick(4);

        // Same, but MIE cleared during the trap: no interrupt trap afterwards.
        mstatus_mie = 1'b1; exception_valid = 1'b1;
        push_trap(1'b0, 31'd11, 32'h2AF3_7BC0, cyc + 1);
        tick(1);
        exception_valid = 1'b0; mstatus_mie = 1'b0;
        tick(5);
        timer_irq = 1'b0;
        tick(2);

        // ext_irq latency with stall=0: SYNC_STAGES+1 cycles.
        mtvec_base = 30'h100;
        mstatus_mie = 1'b1; ext_irq = 1'b1;
        push_trap(1'b1, 31'd11, 32'h0000_0400, cyc + 3);
        tick(3);
        mstatus_mie = 1'b0; ext_irq = 1'b0;
        tick(5);

        // Reset during TRAP: outputs clear next cycle and no strobe follows.
        exception_cause = 4'd9; exception_valid = 1'b1;
        push_trap(1'b0, 31'd9, 32'h0000_0400, cyc + 1);
        tick(1);
        exception_valid = 1'b0; reset_n = 1'b0;
        tick(1);
        chk_all_zero("midreset");
        reset_n = 1'b1;
        tick(5);

        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trap_controller.md
# trap_controller

Sequences machine-mode trap entry and return for the core. Synchronizes and prioritizes the three machine interrupt sources and arbitrates them against synchronous exceptions and `mret`. Produces the single-cycle `trap` / `return_from_trap` strobes, cause, and redirect PC consumed by the CSR file and the fetch stage. It sits between the core pipeline control and the CSR file.

## Interface
- `SYNC_STAGES`, default 2: flop stages on asynchronous `ext_irq`; legal range 2–4.
- `clock` in 1: sole clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ext_irq` in 1: asynchronous external interrupt level.
- `timer_irq` in 1: machine timer interrupt level, synchronous to `clock`.
- `soft_irq` in 1: machine software interrupt level, synchronous.
- `mstatus_mie` in 1: global machine interrupt enable from the CSR file.
- `mie_meie`, `mie_mtie`, `mie_msie` in 1 each: per-source enables.
- `stall` in 1: core is not at an instruction boundary.
- `exception_valid` in 1: core reports a synchronous exception; held until serviced.
- `exception_cause` in 4: exception code, valid with `exception_valid`.
- `mret` in 1: core is executing `mret`; held until serviced.
- `mtvec_base` in 30: `mtvec[31:2]`.
- `mepc` in 30: `mepc[31:2]`.
- `trap` out 1: trap-entry strobe to the CSR file.
- `return_from_trap` out 1: `mret` strobe to the CSR file.
- `interrupt` out 1: cause type; valid with `trap`.
- `exception_code` out 31: cause code; valid with `trap`.
- `redirect_valid` out 1: fetch must load `redirect_pc`.
- `redirect_pc` out 32: new PC.
- `mip_meip`, `mip_mtip`, `mip_msip` out 1 each: registered pending levels for `mip`.
- `busy` out 1: the FSM is not in IDLE; the core holds fetch.

## Operation
- **Pending levels.** `ext_irq` passes through `SYNC_STAGES` flops to form `mip_meip`. `timer_irq` and `soft_irq` are registered once to form `mip_mtip` and `mip_msip`.
- **Interrupt selection.** `take_irq` = `mstatus_mie` & |(pending & enable). Priority is MEI (code 11) > MSI (code 3) > MTI (code 7).
- **IDLE state.**
  - `stall`=1: `exception_valid` and `mret` are ignored.
  - `stall`=0: priority is `exception_valid` > `mret` > `take_irq`.
    - `exception_valid`: latch interrupt=0, code={27'b0, `exception_cause`}; go to TRAP.
    - `mret`: go to RETURN.
    - `take_irq`: latch interrupt=1 and the winning code; go to TRAP.
  - `stall`=1 with `take_irq`: go to DRAIN; nothing is latched.
- **DRAIN state.** Waits for `stall`=0. Then it re-evaluates with the same priority as IDLE and goes to TRAP or RETURN. If nothing is pending any longer (interrupt withdrawn or disabled), it goes to IDLE with no trap.
- **TRAP state.** Lasts one cycle.
  - `trap`=1, `redirect_valid`=1, `redirect_pc`={`mtvec_base`, 2'b00}.
  - `interrupt` and `exception_code` show the latched values.
  - Next state is SETTLE.
- **RETURN state.** Lasts one cycle. `return_from_trap`=1, `redirect_valid`=1, `redirect_pc`={`mepc`, 2'b00}. Next state is SETTLE.
- **SETTLE state.** Lasts one cycle and ignores all requests, so the CSR file's `mstatus_mie` update is visible before the next evaluation. Next state is IDLE.
- **`busy`.** Equals 1 in DRAIN, TRAP, RETURN and SETTLE.
- **Cause registers.** The latched cause holds its value outside TRAP. `interrupt` and `exception_code` are don't-care when `trap`=0 but must not change within a trap sequence.

## Timing
- **Reset.** `reset_n`=0 at a rising edge sets:
  - state to IDLE;
  - all sync flops to 0;
  - all outputs to 0 (`redirect_pc`=0, `exception_code`=0, `mip_*`=0).
  - Reset mid-sequence aborts it, and no strobe is emitted on the next cycle.
- **Strobes.** `trap`, `return_from_trap` and `redirect_valid` are registered, high for exactly one cycle per event, and never high together.
- **Exception latency.** `exception_valid` sampled at edge N with `stall`=0 gives `trap`=1 during cycle N+1.
- **`mret` latency.** Same as exceptions: `return_from_trap`=1 during cycle N+1.
- **Interrupt latency, `timer_irq`/`soft_irq`.** Input rises before edge N, `mip_*` is set after edge N, and `trap` is high in cycle N+2 (`stall`=0, enabled).
- **Interrupt latency, `ext_irq`.** Add `SYNC_STAGES`-1 cycles to the above.
- **Back-to-back limit.** The minimum spacing between two `trap` strobes is 3 cycles (TRAP, SETTLE, then IDLE evaluation).
- **Simultaneous events.** `exception_valid`+`mret`: exception wins, and `mret` stays held by the core. Exception+interrupt: exception wins; the interrupt is re-evaluated after SETTLE.

## Test plan
- **Reset.** Assert `reset_n`=0 during TRAP -> next cycle all outputs 0 and state IDLE; no `trap` pulse follows.
- **Exception.** `exception_valid`=1, `exception_cause`=2, `mtvec_base`=30'h100, `stall`=0 -> next cycle `trap`=1, `interrupt`=0, `exception_code`=2, `redirect_pc`=32'h400; `trap` low for the following 2 cycles.
- **Interrupt priority.** All enables=1, `mstatus_mie`=1, `timer_irq`=`soft_irq`=1 at once -> `trap` 2 cycles later with `exception_code`=3; after the core clears `mstatus_mie`, no second trap.
- **Drain.** `ext_irq` rises with `stall`=1 for 5 cycles -> `busy`=1 after sync, no `trap` until the cycle after `stall` falls, then `exception_code`=11. A repeat with `ext_irq` dropped mid-stall -> back to IDLE, no `trap`.
- **`mret`.** `mepc`=30'h40 with `mret`=1 -> `return_from_trap`=1, `redirect_pc`=32'h100 for one cycle.
- **Exception beats interrupt.** `exception_valid` with cause 11 and `take_irq` both true -> first trap has `interrupt`=0, code 11; the interrupt trap follows only after SETTLE, and only if still enabled.
